// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// It accepts one operation at a time, waits out its EXEC latency and holds the response until the consumer takes it.
module alu_arbiter #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [2:0]  req0_sel,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [2:0]  req1_sel,
  output logic        req1_ready,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_divz,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [3:0] MD_CNT = 4'(MD_LAT - 1);

  function automatic logic is_md_op(input logic [2:0] sel);
    return (sel == 3'b011) || (sel == 3'b100);
  endfunction

  function automatic logic is_divz(input logic [2:0] sel, input logic [31:0] op2);
    return (sel == 3'b100) && (op2 == 32'd0);
  endfunction

  state_t      state_r, state_s;
  logic        last_r;
  logic [3:0]  cnt_r;
  logic [31:0] op1_r, op2_r;
  logic [2:0]  sel_r;
  logic        id_r;
  logic [31:0] res_r;
  logic        zero_r, divz_r;

  logic        grant_id_s;
  logic        take_s;
  logic        last_exec_s;
  logic        divz_s;
  logic [31:0] res_s;
  logic [31:0] g_op1_s, g_op2_s;
  logic [2:0]  g_sel_s;

  // Arbitration: the requester not served last wins a tie; ready is suppressed while in reset.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_r;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    take_s     = (state_r == IDLE) && (req0_valid || req1_valid) && rst_n;
    req0_ready = take_s && !grant_id_s;
    req1_ready = take_s && grant_id_s;
    g_op1_s    = grant_id_s ? req1_op1 : req0_op1;
    g_op2_s    = grant_id_s ? req1_op2 : req0_op2;
    g_sel_s    = grant_id_s ? req1_sel : req0_sel;
  end

  // Result shaping: a divide by zero is forced to zero regardless of what the ALU returns.
  always_comb begin
    last_exec_s = (state_r == EXEC) && (cnt_r == 4'd0);
    divz_s      = is_divz(sel_r, op2_r);
    if (divz_s) begin
      res_s = 32'd0;
    end else begin
      res_s = alu_result;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) state_s = EXEC;
        else        state_s = IDLE;
      end
      EXEC: begin
        if (cnt_r == 4'd0) state_s = RESP;
        else               state_s = EXEC;
      end
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register, operation capture, latency counter and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      cnt_r   <= 4'd0;
      op1_r   <= 32'd0;
      op2_r   <= 32'd0;
      sel_r   <= 3'd0;
      id_r    <= 1'b0;
      res_r   <= 32'd0;
      zero_r  <= 1'b0;
      divz_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (take_s) begin
        op1_r  <= g_op1_s;
        op2_r  <= g_op2_s;
        sel_r  <= g_sel_s;
        id_r   <= grant_id_s;
        last_r <= grant_id_s;
        cnt_r  <= is_md_op(g_sel_s) ? MD_CNT : 4'd0;
      end else if ((state_r == EXEC) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (last_exec_s) begin
        res_r  <= res_s;
        zero_r <= (res_s == 32'd0);
        divz_r <= divz_s;
      end
    end
  end

  assign alu_op1    = op1_r;
  assign alu_op2    = op2_r;
  assign alu_sel    = sel_r;
  assign rsp_valid  = (state_r == RESP);
  assign rsp_id     = id_r;
  assign rsp_result = res_r;
  assign rsp_zero   = zero_r;
  assign rsp_divz   = divz_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle plus directed scenarios with literal expectations.
module tb_alu_arbiter;
  localparam int MD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_sel, req1_sel;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [2:0]  alu_sel;
  logic        rsp_valid, rsp_id, rsp_zero, rsp_divz, rsp_ready;
  logic [31:0] rsp_result;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  alu_arbiter #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel), .req1_ready(req1_ready),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_divz(rsp_divz), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divide by zero returns all-ones so the DUT's forcing to zero is visible.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a * b;
      3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      3'd7: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op1, alu_op2, alu_sel);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: one outstanding operation, response due at accept cycle + latency.
  logic        m_busy, m_last, m_id, m_zero, m_divz;
  logic [31:0] m_res, m_op1, m_op2;
  logic [2:0]  m_sel;
  int          m_resp_cyc;
  int          grant_log[$];

  initial begin
    m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_zero = 1'b0; m_divz = 1'b0;
    m_res = 32'd0; m_op1 = 32'd0; m_op2 = 32'd0; m_sel = 3'd0; m_resp_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_last = 1'b1; m_op1 = 32'd0; m_op2 = 32'd0; m_sel = 3'd0;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_bits", {28'd0, rsp_id, rsp_zero, rsp_divz, 1'b0}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu", alu_op1 | alu_op2 | {29'd0, alu_sel}, 32'd0);
      end else begin
        logic exp_rv, w, g;
        exp_rv = m_busy && (cyc >= m_resp_cyc);
        g = !m_busy && (req0_valid || req1_valid);
        w = (req0_valid && req1_valid) ? !m_last : req1_valid;
        chk("ready0", {31'd0, req0_ready}, {31'd0, g && !w});
        chk("ready1", {31'd0, req1_ready}, {31'd0, g && w});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
        chk("alu_op1", alu_op1, m_op1);
        chk("alu_op2", alu_op2, m_op2);
        chk("alu_sel", {29'd0, alu_sel}, {29'd0, m_sel});
        if (exp_rv) begin
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
          chk("rsp_result", rsp_result, m_res);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
          chk("rsp_divz", {31'd0, rsp_divz}, {31'd0, m_divz});
        end
        if (g) begin
          m_op1  = w ? req1_op1 : req0_op1;
          m_op2  = w ? req1_op2 : req0_op2;
          m_sel  = w ? req1_sel : req0_sel;
          m_id   = w;
          m_divz = (m_sel == 3'd4) && (m_op2 == 32'd0);
          m_res  = m_divz ? 32'd0 : alu_fn(m_op1, m_op2, m_sel);
          m_zero = (m_res == 32'd0);
          m_resp_cyc = cyc + (((m_sel == 3'd3) || (m_sel == 3'd4)) ? 1 + MD_LAT : 2);
          m_last = w;
          m_busy = 1'b1;
          grant_log.push_back(int'(w));
        end else if (exp_rv && rsp_ready) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (!m_busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drive(input int r, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      req0_valid = 1'b1; req0_sel = s; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = 1'b1; req1_sel = s; req1_op1 = a; req1_op2 = b;
    end
  endtask

  int t, c, hold;

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op1 = 32'd0; req0_op2 = 32'd0; req0_sel = 3'd0;
    req1_valid = 1'b0; req1_op1 = 32'd0; req1_op2 = 32'd0; req1_sel = 3'd0;
    step(); step();
    rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate, 9-9 gives a zero result.
    grant_log.delete();
    drive(0, 3'd1, 32'd9, 32'd9);
    drive(1, 3'd1, 32'd9, 32'd9);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (grant_log.size() >= 4) break;
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", grant_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("rr_order", grant_log[i], i % 2);
    end
    wait_idle();

    // Single-cycle add on requester 0.
    step();
    drive(0, 3'd0, 32'd5, 32'd7);
    @(negedge clk);
    t = cyc;
    chk("add_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    wait_rsp(c);
    chk("add_latency", c - t, 32'd2);
    chk("add_result", rsp_result, 32'd12);
    chk("add_zero", {31'd0, rsp_zero}, 32'd0);
    chk("add_id", {31'd0, rsp_id}, 32'd0);
    wait_idle();

    // Multi-cycle multiply on requester 1.
    step();
    drive(1, 3'd3, 32'd6, 32'd7);
    @(negedge clk);
    t = cyc;
    step();
    req1_valid = 1'b0;
    wait_rsp(c);
    chk("mul_latency", c - t, 32'd5);
    chk("mul_result", rsp_result, 32'd42);
    chk("mul_id", {31'd0, rsp_id}, 32'd1);
    wait_idle();

    // Divide by zero, then a normal divide.
    step();
    drive(0, 3'd4, 32'd10, 32'd0);
    step();
    req0_valid = 1'b0;
    wait_rsp(c);
    chk("divz_flag", {31'd0, rsp_divz}, 32'd1);
    chk("divz_result", rsp_result, 32'd0);
    chk("divz_zero", {31'd0, rsp_zero}, 32'd1);
    wait_idle();
    step();
    drive(0, 3'd4, 32'd10, 32'd3);
    step();
    req0_valid = 1'b0;
    wait_rsp(c);
    chk("div_result", rsp_result, 32'd3);
    chk("div_flag", {31'd0, rsp_divz}, 32'd0);
    wait_idle();

    // Backpressure: response held while req0 waits; req1 pulses valid and withdraws.
    step();
    rsp_ready = 1'b0;
    drive(0, 3'd0, 32'd1, 32'd2);
    step();
    req0_valid = 1'b0;
    wait_rsp(c);
    step();
    drive(0, 3'd2, 32'h0000_00FF, 32'h0000_000F);
    drive(1, 3'd0, 32'd1, 32'd1);
    for (hold = 0; hold < 5; hold++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'd3);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      step();
      req1_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready0", {31'd0, req0_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("bp_grant_after", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    wait_rsp(c);
    chk("bp_and_result", rsp_result, 32'h0000_000F);
    wait_idle();

    // Reset in the middle of a divide's EXEC.
    step();
    drive(0, 3'd4, 32'd100, 32'd7);
    step();
    req0_valid = 1'b0;
    step();
    drive(1, 3'd0, 32'd3, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
    chk("mid_rst_alu_op1", alu_op1, 32'd0);
    chk("mid_rst_alu_op2", alu_op2, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    req1_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    step();
    drive(1, 3'd0, 32'd3, 32'd4);
    @(negedge clk);
    t = cyc;
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp(c);
    chk("post_rst_latency", c - t, 32'd2);
    chk("post_rst_result", rsp_result, 32'd7);
    chk("post_rst_id", {31'd0, rsp_id}, 32'd1);
    wait_idle();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
